// File: rtl/e_core_boot_seq_pkg.sv
// e_core_boot_pkg: shared types and constants for the e_core boot sequencer.
//   boot_state_e : sequencer state, also exported on state_o
//   STOP_CLK_DLY : cycles between reset assertion and clock gating in STOP
//   max3         : elaboration-time helper used to size the shared counters
package e_core_boot_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLK_ON  = 3'd1,
      RELEASE = 3'd2,
      RUN     = 3'd3,
      STOP    = 3'd4
   } boot_state_e;

   localparam int STOP_CLK_DLY = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/e_core_boot_seq_if.sv
// e_core_boot_seq_if: control/status bundle between the boot sequencer and the
// e_core subsystem it drives.
//   slave  : sequencer side (takes start/stop/halted/fault, drives gates/resets/status)
//   master : requester/core side
// Optional: E_CORE_BOOT_WDT_EN adds wdt_kick_i / wdt_expired_o.
interface e_core_boot_seq_if
   import e_core_boot_pkg::*;
#(
   parameter int NUM_CORES = 4
);
   logic                 start_i;
   logic                 stop_i;
   logic [NUM_CORES-1:0] core_halted_i;
   logic [NUM_CORES-1:0] core_fault_i;
   logic [NUM_CORES-1:0] core_clk_en_o;
   logic [NUM_CORES-1:0] core_rst_n_o;
   logic [NUM_CORES-1:0] fault_mask_o;
   boot_state_e          state_o;
   logic                 busy_o;
   logic                 done_o;
`ifdef E_CORE_BOOT_WDT_EN
   logic                 wdt_kick_i;
   logic                 wdt_expired_o;
`endif

   modport slave (
      input  start_i, stop_i, core_halted_i, core_fault_i,
`ifdef E_CORE_BOOT_WDT_EN
      input  wdt_kick_i,
      output wdt_expired_o,
`endif
      output core_clk_en_o, core_rst_n_o, fault_mask_o, state_o, busy_o, done_o
   );

   modport master (
      output start_i, stop_i, core_halted_i, core_fault_i,
`ifdef E_CORE_BOOT_WDT_EN
      output wdt_kick_i,
      input  wdt_expired_o,
`endif
      input  core_clk_en_o, core_rst_n_o, fault_mask_o, state_o, busy_o, done_o
   );

endinterface

// File: rtl/e_core_boot_seq_cnt.sv
// e_core_boot_cnt: loadable down-counter that parks at zero.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val this cycle (wins over counting)
//   load_val  : value to load
//   zero      : counter currently holds zero
module e_core_boot_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (load)        cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/e_core_boot_seq.sv
// e_core_boot_seq: clock-enable / reset bring-up sequencer for NUM_CORES e_cores.
//   io_aclk, io_areset : clock, async active-high reset
//   bus (slave)        : start/stop requests, per-core halted/fault in;
//                        per-core clk_en/rst_n, sticky fault mask, state/busy/done out
// Optional: E_CORE_BOOT_WDT_EN adds a RUN-state watchdog (wdt_kick_i/wdt_expired_o).
module e_core_boot_seq
   import e_core_boot_pkg::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int RST_CYCLES     = 10,
   parameter int STAGGER_CYCLES = 4,
   parameter int AUTO_RESTART   = 0,
   parameter int WDT_CYCLES     = 1024
) (
   input logic             io_aclk,
   input logic             io_areset,
   e_core_boot_seq_if.slave bus
);

   localparam int  CNT_W = $clog2(max3(RST_CYCLES, STAGGER_CYCLES, WDT_CYCLES) + 1);
   localparam int  IDX_W = $clog2(NUM_CORES + 1);
   localparam int  SC_W  = $clog2(STOP_CLK_DLY + 1);
   localparam bit  AR    = (AUTO_RESTART != 0);

   boot_state_e          state;
   logic [NUM_CORES-1:0] clk_en, rst_n, mask;
   logic                 busy, done, restart_pend;
   logic [IDX_W-1:0]     idx;
   logic [SC_W-1:0]      stop_cnt;
   logic                 stop_last;
   logic                 seq_load, seq_zero;
   logic [CNT_W-1:0]     seq_val;
   logic                 wdt_exp;

   assign stop_last = (stop_cnt == SC_W'(STOP_CLK_DLY - 1));

   // Sequencing counter: RST_CYCLES-1 on (re)entry to CLK_ON, STAGGER_CYCLES-1
   // after every release.
   always_comb begin
      seq_load = 1'b0;
      seq_val  = CNT_W'(STAGGER_CYCLES - 1);
      case (state)
         IDLE: if (bus.start_i) begin
            seq_load = 1'b1;
            seq_val  = CNT_W'(RST_CYCLES - 1);
         end
         CLK_ON, RELEASE: seq_load = seq_zero;
         STOP: if (stop_last && restart_pend) begin
            seq_load = 1'b1;
            seq_val  = CNT_W'(RST_CYCLES - 1);
         end
         default: ;
      endcase
   end

   e_core_boot_cnt #(.W(CNT_W)) u_seq_cnt (
      .clk      (io_aclk),
      .rst      (io_areset),
      .load     (seq_load),
      .load_val (seq_val),
      .zero     (seq_zero)
   );

`ifdef E_CORE_BOOT_WDT_EN
   logic wdt_zero, wdt_load, wdt_expired;

   // Held at full count outside RUN so it starts fresh on RUN entry.
   assign wdt_load = (state != RUN) || bus.wdt_kick_i;
   assign wdt_exp  = (state == RUN) && !bus.wdt_kick_i && wdt_zero;

   e_core_boot_cnt #(.W(CNT_W)) u_wdt_cnt (
      .clk      (io_aclk),
      .rst      (io_areset),
      .load     (wdt_load),
      .load_val (CNT_W'(WDT_CYCLES - 1)),
      .zero     (wdt_zero)
   );

   always_ff @(posedge io_aclk or posedge io_areset) begin
      if (io_areset)                          wdt_expired <= 1'b0;
      else if (state == IDLE && bus.start_i)  wdt_expired <= 1'b0;
      else if (wdt_exp)                       wdt_expired <= 1'b1;
   end

   assign bus.wdt_expired_o = wdt_expired;
`else
   assign wdt_exp = 1'b0;
`endif

   always_ff @(posedge io_aclk or posedge io_areset) begin
      if (io_areset) begin
         state        <= IDLE;
         clk_en       <= '0;
         rst_n        <= '0;
         mask         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         restart_pend <= 1'b0;
         idx          <= '0;
         stop_cnt     <= '0;
      end else begin
         done <= 1'b0;
         if (state != STOP) stop_cnt <= '0;
         // Only cores already out of reset can report a fault.
         if (state inside {CLK_ON, RELEASE, RUN})
            mask <= mask | (bus.core_fault_i & rst_n);

         case (state)
            IDLE: if (bus.start_i) begin
               state  <= CLK_ON;
               busy   <= 1'b1;
               clk_en <= '1;
               rst_n  <= '0;
               mask   <= '0;
            end

            // Core 0 is released on the cycle CLK_ON times out so that core i
            // comes out of reset exactly RST_CYCLES + i*STAGGER_CYCLES cycles
            // after CLK_ON entry; RELEASE handles cores 1..NUM_CORES-1.
            CLK_ON: begin
               if (bus.stop_i) begin
                  state        <= STOP;
                  rst_n        <= '0;
                  restart_pend <= 1'b0;
               end else if (seq_zero) begin
                  rst_n[0] <= 1'b1;
                  idx      <= IDX_W'(1);
                  state    <= (NUM_CORES == 1) ? RUN : RELEASE;
               end
            end

            RELEASE: begin
               if (bus.stop_i) begin
                  state        <= STOP;
                  rst_n        <= '0;
                  restart_pend <= 1'b0;
               end else if (seq_zero) begin
                  for (int i = 0; i < NUM_CORES; i++)
                     if (idx == IDX_W'(i)) rst_n[i] <= 1'b1;
                  idx <= idx + 1'b1;
                  if (idx == IDX_W'(NUM_CORES - 1)) state <= RUN;
               end
            end

            // Faulting cores get their clock frozen for debug; reset stays high.
            RUN: begin
               clk_en <= clk_en & ~bus.core_fault_i;
               if (wdt_exp) mask <= '1;
               if (bus.stop_i || (&bus.core_halted_i)) begin
                  state        <= STOP;
                  rst_n        <= '0;
                  restart_pend <= 1'b0;
               end else if (wdt_exp || (AR && (|bus.core_fault_i))) begin
                  state        <= STOP;
                  rst_n        <= '0;
                  restart_pend <= AR;
               end
            end

            // Resets go low on entry; clocks are gated STOP_CLK_DLY cycles later.
            STOP: begin
               if (stop_last) begin
                  if (restart_pend) begin
                     state  <= CLK_ON;
                     clk_en <= '1;
                  end else begin
                     state  <= IDLE;
                     clk_en <= '0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end
                  restart_pend <= 1'b0;
               end else begin
                  stop_cnt <= stop_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.core_clk_en_o = clk_en;
   assign bus.core_rst_n_o  = rst_n;
   assign bus.fault_mask_o  = mask;
   assign bus.state_o       = state;
   assign bus.busy_o        = busy;
   assign bus.done_o        = done;

endmodule
